// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes,
// response error codes and the default data-memory base address.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'hFFFF_0000;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic: extracts and extends the addressed byte/half of a loaded word,
// and merges store data into the addressed lanes of a read word. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = rdata[7:0];
        case (offset)
            2'd0:    byte_val = rdata[7:0];
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            default: byte_val = rdata[31:24];
        endcase
        half_val = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_BU:   load_data = {24'h0, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_HU:   load_data = {16'h0, half_val};
            default: load_data = rdata;
        endcase

        store_data = rdata;
        case (funct3)
            F3_B:    store_data[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (offset[1])
                    store_data[31:16] = wdata[15:0];
                else
                    store_data[15:0] = wdata[15:0];
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a core request port to a word-wide, registered-read data memory.
// Define LSU_MISALIGN_TRAP_EN to report misalignment as an error instead of masking the low address bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
    parameter int unsigned DMEM_WORDS = 65536
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData,
    output logic        Write_EN,
    input  logic [31:0] Read_Data
);

    // Limit is computed wider than 32 bits: the default window ends past 2^32.
    localparam logic [34:0] DMEM_LIMIT = {3'b000, DMEM_BASE} + ({3'b000, DMEM_WORDS} << 2);

    lsu_state_t  state, state_nxt;
    logic        live_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        in_range;
    logic        misal_trap;
    logic [1:0]  acc_err;
    logic [31:0] addr_fix;
    logic [31:0] word_addr;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign accept   = req_valid && req_ready;
    assign in_range = ({3'b000, req_addr} >= {3'b000, DMEM_BASE}) &&
                      ({3'b000, req_addr} < DMEM_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal_trap = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                        ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    assign addr_fix   = req_addr;
`else
    assign misal_trap = 1'b0;
    always_comb begin
        addr_fix = req_addr;
        if (req_funct3 == F3_W)
            addr_fix[1:0] = 2'b00;
        else if ((req_funct3 == F3_H) || (req_funct3 == F3_HU))
            addr_fix[0] = 1'b0;
    end
`endif

    always_comb begin
        acc_err = ERR_OK;
        if (!f3_legal(req_we, req_funct3))
            acc_err = ERR_ILLEGAL;
        else if (!in_range)
            acc_err = ERR_RANGE;
        else if (misal_trap)
            acc_err = ERR_MISALIGN;
    end

    // Memory is indexed by word: base plus the word offset, not a byte address.
    assign word_addr = DMEM_BASE + ((addr_q - DMEM_BASE) >> 2);

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .rdata      (Read_Data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        Write_EN   = 1'b0;
        ALUResult  = 32'h0;
        WriteData  = 32'h0;
        case (state)
            IDLE: begin
                req_ready = live_q;
                if (accept) begin
                    if (acc_err != ERR_OK)
                        state_nxt = RESP;
                    else if (req_we && (req_funct3 == F3_W))
                        state_nxt = WR_ISSUE;
                    else
                        state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                ALUResult = word_addr;
                state_nxt = RD_CAPTURE;
            end
            RD_CAPTURE: state_nxt = we_q ? WR_ISSUE : RESP;
            WR_ISSUE: begin
                ALUResult = word_addr;
                WriteData = wdata_q;
                Write_EN  = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            live_q     <= 1'b0;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= ERR_OK;
        end else begin
            state  <= state_nxt;
            live_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= addr_fix;
                        wdata_q <= req_wdata;
                        if (acc_err != ERR_OK) begin
                            resp_err   <= acc_err;
                            resp_rdata <= 32'h0;
                        end
                    end
                end
                RD_CAPTURE: begin
                    if (we_q) begin
                        wdata_q <= store_data;
                    end else begin
                        resp_rdata <= load_data;
                        resp_err   <= ERR_OK;
                    end
                end
                WR_ISSUE: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= ERR_OK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses and
// writes; a negedge monitor pops and compares them against a registered-read memory model.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        Write_EN;
    logic [31:0] Read_Data;

    load_store_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .Write_EN   (Write_EN),
        .Read_Data  (Read_Data)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:63];
    logic [31:0] idx_full;
    assign idx_full = ALUResult - BASE;

    always @(posedge CLK) begin
        if (Write_EN) mem[idx_full[5:0]] <= WriteData;
        Read_Data <= mem[idx_full[5:0]];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          acc;
    } resp_exp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    resp_exp_t sb_q[$];
    wr_exp_t   wr_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge CLK) begin
        resp_exp_t e;
        wr_exp_t   w;
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                fail_now("unexpected response");
            end else begin
                e = sb_q.pop_front();
                chk({e.name, " rdata"}, resp_rdata, e.rdata);
                chk({e.name, " err"}, {30'h0, resp_err}, {30'h0, e.err});
                chk({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
        if (Write_EN) begin
            if (wr_q.size() == 0) begin
                fail_now("unexpected write");
            end else begin
                w = wr_q.pop_front();
                chk({w.name, " waddr"}, ALUResult, w.addr);
                chk({w.name, " wdata"}, WriteData, w.data);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (req_ready) break;
        end
        if (!req_ready) fail_now("req_ready timeout");
    endtask

    task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic [1:0] exp_err, input int exp_lat,
                          input bit has_wr, input logic [31:0] wa, input logic [31:0] wdat);
        resp_exp_t e;
        wr_exp_t   w;
        wait_ready();
        if (has_wr) begin
            w.name = nm; w.addr = wa; w.data = wdat;
            wr_q.push_back(w);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge CLK);
        #1;
        e.name = nm; e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
        sb_q.push_back(e);
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0 && wr_q.size() == 0) break;
            @(negedge CLK);
        end
        if (sb_q.size() != 0 || wr_q.size() != 0) begin
            fail_now({nm, " completion timeout"});
            sb_q.delete();
            wr_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", {30'h0, resp_err}, 32'h0);
        chk("rst ALUResult", ALUResult, 32'h0);
        chk("rst WriteData", WriteData, 32'h0);
        chk("rst Write_EN", {31'h0, Write_EN}, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("ready before first edge", {31'h0, req_ready}, 32'h0);
        @(posedge CLK);
        #1;
        chk("ready after first edge", {31'h0, req_ready}, 32'h1);

        // name, we, f3, addr, wdata, exp rdata, exp err, latency, write?, waddr, wdata
        do_req("SW 08",  1'b1, 3'b010, 32'hFFFF0008, 32'hDEADBEEF, 32'h0, 2'b00, 2, 1'b1, 32'hFFFF0002, 32'hDEADBEEF);
        do_req("LW 08",  1'b0, 3'b010, 32'hFFFF0008, 32'h0, 32'hDEADBEEF, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("SW 10",  1'b1, 3'b010, 32'hFFFF0010, 32'h11223344, 32'h0, 2'b00, 2, 1'b1, 32'hFFFF0004, 32'h11223344);
        do_req("SB 11",  1'b1, 3'b000, 32'hFFFF0011, 32'h000000AA, 32'h0, 2'b00, 4, 1'b1, 32'hFFFF0004, 32'h1122AA44);
        do_req("LW 10",  1'b0, 3'b010, 32'hFFFF0010, 32'h0, 32'h1122AA44, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("SW 20",  1'b1, 3'b010, 32'hFFFF0020, 32'h000080F0, 32'h0, 2'b00, 2, 1'b1, 32'hFFFF0008, 32'h000080F0);
        do_req("LB 20",  1'b0, 3'b000, 32'hFFFF0020, 32'h0, 32'hFFFFFFF0, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("LBU 20", 1'b0, 3'b100, 32'hFFFF0020, 32'h0, 32'h000000F0, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("LH 20",  1'b0, 3'b001, 32'hFFFF0020, 32'h0, 32'hFFFF80F0, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("LHU 20", 1'b0, 3'b101, 32'hFFFF0020, 32'h0, 32'h000080F0, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("LB 21",  1'b0, 3'b000, 32'hFFFF0021, 32'h0, 32'hFFFFFF80, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("LHU 22", 1'b0, 3'b101, 32'hFFFF0022, 32'h0, 32'h00000000, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("SW 04",  1'b1, 3'b010, 32'hFFFF0004, 32'h0BADF00D, 32'h0, 2'b00, 2, 1'b1, 32'hFFFF0001, 32'h0BADF00D);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("LW 06",  1'b0, 3'b010, 32'hFFFF0006, 32'h0, 32'h0, 2'b01, 1, 1'b0, 32'h0, 32'h0);
        do_req("SH 13",  1'b1, 3'b001, 32'hFFFF0013, 32'h00005566, 32'h0, 2'b01, 1, 1'b0, 32'h0, 32'h0);
        do_req("LW 10b", 1'b0, 3'b010, 32'hFFFF0010, 32'h0, 32'h1122AA44, 2'b00, 3, 1'b0, 32'h0, 32'h0);
`else
        do_req("LW 06",  1'b0, 3'b010, 32'hFFFF0006, 32'h0, 32'h0BADF00D, 2'b00, 3, 1'b0, 32'h0, 32'h0);
        do_req("SH 13",  1'b1, 3'b001, 32'hFFFF0013, 32'h00005566, 32'h0, 2'b00, 4, 1'b1, 32'hFFFF0004, 32'h5566AA44);
        do_req("LW 10b", 1'b0, 3'b010, 32'hFFFF0010, 32'h0, 32'h5566AA44, 2'b00, 3, 1'b0, 32'h0, 32'h0);
`endif
        do_req("L f3=011",   1'b0, 3'b011, 32'hFFFF0008, 32'h0, 32'h0, 2'b11, 1, 1'b0, 32'h0, 32'h0);
        do_req("S f3=011",   1'b1, 3'b011, 32'hFFFF0008, 32'h1, 32'h0, 2'b11, 1, 1'b0, 32'h0, 32'h0);
        do_req("S f3=100",   1'b1, 3'b100, 32'hFFFF0008, 32'h1, 32'h0, 2'b11, 1, 1'b0, 32'h0, 32'h0);
        do_req("LW range",   1'b0, 3'b010, 32'h00001000, 32'h0, 32'h0, 2'b10, 1, 1'b0, 32'h0, 32'h0);
        do_req("SB range",   1'b1, 3'b000, 32'h00001000, 32'h5, 32'h0, 2'b10, 1, 1'b0, 32'h0, 32'h0);
        do_req("ill+range",  1'b0, 3'b110, 32'h00001001, 32'h0, 32'h0, 2'b11, 1, 1'b0, 32'h0, 32'h0);
        do_req("LW 08 again", 1'b0, 3'b010, 32'hFFFF0008, 32'h0, 32'hDEADBEEF, 2'b00, 3, 1'b0, 32'h0, 32'h0);

        // SB interrupted by reset while its write is on the bus.
        begin
            wr_exp_t w;
            bit seen;
            wait_ready();
            w.name = "aborted SB"; w.addr = 32'hFFFF0008; w.data = 32'h00008077;
            wr_q.push_back(w);
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
            req_addr = 32'hFFFF0020; req_wdata = 32'h00000077;
            @(posedge CLK);
            #1;
            req_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge CLK);
                if (Write_EN) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail_now("aborted SB never reached write");
            #2;
            RST = 1'b0;
            #1;
            chk("abort Write_EN", {31'h0, Write_EN}, 32'h0);
            chk("abort ALUResult", ALUResult, 32'h0);
            chk("abort resp_valid", {31'h0, resp_valid}, 32'h0);
            chk("abort req_ready", {31'h0, req_ready}, 32'h0);
            repeat (2) @(negedge CLK);
            RST = 1'b1;
            #1;
            chk("abort ready pre-edge", {31'h0, req_ready}, 32'h0);
            @(posedge CLK);
            #1;
            chk("abort ready post-edge", {31'h0, req_ready}, 32'h1);
            wr_q.delete();
        end
        do_req("LW 20 after abort", 1'b0, 3'b010, 32'hFFFF0020, 32'h0, 32'h000080F0, 2'b00, 3, 1'b0, 32'h0, 32'h0);

        repeat (3) @(negedge CLK);
        chk("leftover expectations", 32'(sb_q.size() + wr_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DMEM_BASE, default 32'hFFFF_0000, byte address of data-memory word 0.
REQ-002 SHALL have parameter DMEM_WORDS, default 65536, data-memory depth in 32-bit words.
REQ-003 SHALL have one clock and asynchronous active-low reset: CLK input 1, rising-edge clock; RST input 1, asynchronous reset, active low.
REQ-004 SHALL have core-side ports:
- req_valid input 1
- req_ready output 1
- req_we input 1 (1 = store)
- req_funct3 input 3
- req_addr input 32 (byte address)
- req_wdata input 32
REQ-005 SHALL have response ports:
- resp_valid output 1
- resp_rdata output 32
- resp_err output 2 (00 ok, 01 misaligned, 10 out of range, 11 illegal funct3)
REQ-006 SHALL have memory-side ports, matching the team's word-wide data memory (registered read, one-cycle latency):
- ALUResult output 32 (memory address)
- WriteData output 32
- Write_EN output 1
- Read_Data input 32

Function
REQ-007 SHALL use FSM states IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, RESP.
REQ-008 SHALL assert req_ready only in IDLE; a request is accepted when req_valid&&req_ready at a rising edge, and all req_* are latched then.
REQ-009 SHALL decode funct3 as follows:
- loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- stores: 000 SB, 001 SH, 010 SW
- any other code is illegal
REQ-010 SHALL check errors at acceptance with priority illegal > out of range (addr < DMEM_BASE or addr >= DMEM_BASE+4*DMEM_WORDS) > misaligned (LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0).
REQ-011 SHALL, on an error, go IDLE->RESP, assert Write_EN on no cycle, and return resp_rdata=0.
REQ-012 SHALL drive ALUResult = DMEM_BASE + ((addr-DMEM_BASE)>>2) in RD_ISSUE and WR_ISSUE; ALUResult SHALL be 0 otherwise.
REQ-013 SHALL sequence loads IDLE->RD_ISSUE->RD_CAPTURE->RESP, giving resp_valid 3 cycles after the acceptance edge.
REQ-014 SHALL, in RD_CAPTURE, sample Read_Data, select the byte/half by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), and register the result.
REQ-015 SHALL sequence SW as IDLE->WR_ISSUE->RESP, with Write_EN=1 and WriteData=req_wdata for exactly one cycle.
REQ-016 SHALL perform SB/SH as read-modify-write IDLE->RD_ISSUE->RD_CAPTURE->WR_ISSUE->RESP, merging only the addressed byte/half lanes of req_wdata into the read word.
REQ-017 SHALL hold resp_valid high for exactly one cycle in RESP, with no backpressure, then return to IDLE; resp_rdata/resp_err SHALL hold until the next response.
REQ-018 SHALL keep Write_EN low in every state except WR_ISSUE.
REQ-019 SHALL return resp_rdata=0 for stores.

Reset
REQ-020 SHALL, while RST=0, immediately force state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=00, ALUResult=0, WriteData=0, Write_EN=0.
REQ-021 SHALL abandon a transaction interrupted by reset mid-operation without any write or response; req_ready SHALL rise on the first edge after RST deasserts.

Configuration
REQ-022 SHALL, with LSU_MISALIGN_TRAP_EN defined, report misalignment as resp_err=01 per REQ-010/011.
REQ-023 SHALL, without LSU_MISALIGN_TRAP_EN, never report 01; instead it SHALL force the offending low address bits to 0 and perform the access normally.

Structure
REQ-024 SHALL take from shared package lsu_pkg: the state enum, funct3 constants, resp_err codes, and the DMEM_BASE default.
REQ-025 SHALL place lane extract/extend and store-merge logic in one combinational sub-module, lsu_align.

Verification
REQ-026 SHALL cover the following directed scenarios:
- SW addr=FFFF0008 data=DEADBEEF, then LW FFFF0008 -> Write_EN one cycle at ALUResult=FFFF0002; resp_rdata=DEADBEEF 3 cycles after acceptance.
- Word FFFF0010=11223344, SB addr=FFFF0011 data=000000AA -> read-modify-write writes 1122AA44; resp_valid 4 cycles after acceptance.
- Word=0000_80F0 at FFFF0020: LB FFFF0020 -> FFFFFFF0; LBU -> 000000F0; LH -> FFFF80F0; LHU -> 000080F0.
- LW addr=FFFF0006 -> with macro: resp_err=01, no Write_EN, 1-cycle response; without macro: reads word FFFF0004.
- funct3=011 -> resp_err=11; addr=00001000 -> resp_err=10; neither touches memory.
- RST low during WR_ISSUE of SB -> Write_EN drops immediately, no resp_valid; memory word unchanged apart from any write completed before reset.
